// File: rtl/decode_stage.sv
// RV32I decode stage: registered control/immediate bundle, load-use stall, sticky halt; DECODE_MULDIV_EN adds M-ext R ops.
// Latency: 1 cycle from input acceptance to out_valid.
// Backpressure: out_* hold while out_valid & !out_ready; in_ready drops on stall, hazard, flush or halt.
module decode_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            ex_mem_read,
    input  logic [4:0]      ex_rd,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [2:0]      out_itype,
    output logic [XLEN-1:0] out_imm,
    output logic            out_reg_write,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic            out_alu_src,
    output logic            out_branch,
    output logic            out_jal,
    output logic            out_jalr,
    output logic            out_lui,
    output logic            out_auipc,
    output logic            out_hlt,
    output logic            out_illegal,
    output logic            out_mul,
    output logic            halted
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("decode_stage: XLEN must be 32 or 64");
    end

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_HALT   = 7'b1111111;

    typedef enum logic {
        ST_RUN,
        ST_HALTED
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [2:0]      itype;
        logic [XLEN-1:0] imm;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            alu_src;
        logic            branch;
        logic            jal;
        logic            jalr;
        logic            lui;
        logic            auipc;
        logic            hlt;
        logic            illegal;
        logic            mul;
    } bundle_t;

    state_t      state_q;
    bundle_t     bundle_q;
    bundle_t     bundle_d;
    logic        out_valid_q;
    logic        use_rs1;
    logic        use_rs2;
    logic        hazard;
    logic        accept;
    logic [31:0] imm32;
    logic        is_muldiv;

    assign is_muldiv = (in_instr[31:25] == 7'b0000001);

    always_comb begin
        bundle_d        = '0;
        bundle_d.pc     = in_pc;
        bundle_d.rs1    = in_instr[19:15];
        bundle_d.rs2    = in_instr[24:20];
        bundle_d.rd     = in_instr[11:7];
        bundle_d.funct3 = in_instr[14:12];
        bundle_d.funct7 = in_instr[31:25];
        bundle_d.itype  = in_instr[6:4];
        use_rs1         = 1'b0;
        use_rs2         = 1'b0;
        imm32           = 32'd0;

        case (in_instr[6:0])
            OP_R: begin
`ifdef DECODE_MULDIV_EN
                bundle_d.reg_write = 1'b1;
                bundle_d.mul       = is_muldiv;
                use_rs1            = 1'b1;
                use_rs2            = 1'b1;
`else
                if (is_muldiv) begin
                    bundle_d.illegal = 1'b1;
                end else begin
                    bundle_d.reg_write = 1'b1;
                    use_rs1            = 1'b1;
                    use_rs2            = 1'b1;
                end
`endif
            end
            OP_IALU: begin
                bundle_d.reg_write = 1'b1;
                bundle_d.alu_src   = 1'b1;
                use_rs1            = 1'b1;
                imm32              = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            OP_LOAD: begin
                bundle_d.reg_write = 1'b1;
                bundle_d.mem_read  = 1'b1;
                bundle_d.alu_src   = 1'b1;
                use_rs1            = 1'b1;
                imm32              = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            OP_STORE: begin
                bundle_d.mem_write = 1'b1;
                bundle_d.alu_src   = 1'b1;
                use_rs1            = 1'b1;
                use_rs2            = 1'b1;
                imm32              = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            OP_BRANCH: begin
                bundle_d.branch = 1'b1;
                use_rs1         = 1'b1;
                use_rs2         = 1'b1;
                imm32           = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                                   in_instr[30:25], in_instr[11:8], 1'b0};
            end
            OP_JAL: begin
                bundle_d.reg_write = 1'b1;
                bundle_d.jal       = 1'b1;
                imm32              = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                                      in_instr[20], in_instr[30:21], 1'b0};
            end
            OP_JALR: begin
                bundle_d.reg_write = 1'b1;
                bundle_d.jalr      = 1'b1;
                bundle_d.alu_src   = 1'b1;
                use_rs1            = 1'b1;
                imm32              = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            OP_LUI: begin
                bundle_d.reg_write = 1'b1;
                bundle_d.alu_src   = 1'b1;
                bundle_d.lui       = 1'b1;
                imm32              = {in_instr[31:12], 12'd0};
            end
            OP_AUIPC: begin
                bundle_d.reg_write = 1'b1;
                bundle_d.alu_src   = 1'b1;
                bundle_d.auipc     = 1'b1;
                imm32              = {in_instr[31:12], 12'd0};
            end
            OP_HALT: begin
                bundle_d.hlt = 1'b1;
            end
            default: begin
                bundle_d.illegal = 1'b1;
            end
        endcase

        // x0 is hardwired, so a write to it is never a real write
        if (in_instr[11:7] == 5'd0) begin
            bundle_d.reg_write = 1'b0;
        end
        bundle_d.imm = XLEN'($signed(imm32));
    end

    assign hazard = in_valid & ex_mem_read & (ex_rd != 5'd0) &
                    ((use_rs1 & (bundle_d.rs1 == ex_rd)) |
                     (use_rs2 & (bundle_d.rs2 == ex_rd)));

    // Gated by rst_n so nothing is accepted while reset is held
    assign in_ready = rst_n & (state_q == ST_RUN) & ~flush & ~hazard &
                      (~out_valid_q | out_ready);
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            out_valid_q <= 1'b0;
            bundle_q    <= '0;
        end else begin
            if (flush) begin
                out_valid_q <= 1'b0;
            end else if (accept) begin
                bundle_q    <= bundle_d;
                out_valid_q <= 1'b1;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end

            case (state_q)
                ST_RUN: begin
                    if (accept && bundle_d.hlt) begin
                        state_q <= ST_HALTED;
                    end
                end
                default: state_q <= ST_HALTED;
            endcase
        end
    end

    assign halted        = (state_q == ST_HALTED);
    assign out_valid     = out_valid_q;
    assign out_pc        = bundle_q.pc;
    assign out_rs1       = bundle_q.rs1;
    assign out_rs2       = bundle_q.rs2;
    assign out_rd        = bundle_q.rd;
    assign out_funct3    = bundle_q.funct3;
    assign out_funct7    = bundle_q.funct7;
    assign out_itype     = bundle_q.itype;
    assign out_imm       = bundle_q.imm;
    assign out_reg_write = bundle_q.reg_write;
    assign out_mem_read  = bundle_q.mem_read;
    assign out_mem_write = bundle_q.mem_write;
    assign out_alu_src   = bundle_q.alu_src;
    assign out_branch    = bundle_q.branch;
    assign out_jal       = bundle_q.jal;
    assign out_jalr      = bundle_q.jalr;
    assign out_lui       = bundle_q.lui;
    assign out_auipc     = bundle_q.auipc;
    assign out_hlt       = bundle_q.hlt;
    assign out_illegal   = bundle_q.illegal;
    assign out_mul       = bundle_q.mul;

endmodule

// File: tb/tb_decode_stage.sv
// Directed-vector bench for decode_stage: decode table plus hazard, stall, flush, halt and reset sequences.
module tb_decode_stage;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            ex_mem_read;
    logic [4:0]      ex_rd;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [4:0]      out_rs1, out_rs2, out_rd;
    logic [2:0]      out_funct3;
    logic [6:0]      out_funct7;
    logic [2:0]      out_itype;
    logic [XLEN-1:0] out_imm;
    logic            out_reg_write, out_mem_read, out_mem_write, out_alu_src;
    logic            out_branch, out_jal, out_jalr, out_lui, out_auipc;
    logic            out_hlt, out_illegal, out_mul, halted;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_funct3(out_funct3), .out_funct7(out_funct7), .out_itype(out_itype),
        .out_imm(out_imm), .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
        .out_mem_write(out_mem_write), .out_alu_src(out_alu_src), .out_branch(out_branch),
        .out_jal(out_jal), .out_jalr(out_jalr), .out_lui(out_lui), .out_auipc(out_auipc),
        .out_hlt(out_hlt), .out_illegal(out_illegal), .out_mul(out_mul), .halted(halted)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // {reg_write, mem_read, mem_write, alu_src, branch, jal, jalr, lui, auipc, hlt, illegal, mul}
    function automatic logic [11:0] ctrl();
        return {out_reg_write, out_mem_read, out_mem_write, out_alu_src, out_branch,
                out_jal, out_jalr, out_lui, out_auipc, out_hlt, out_illegal, out_mul};
    endfunction

    function automatic logic [XLEN-1:0] sx(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [11:0] ctrl;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  itype;
    } vec_t;

    vec_t vecs[12];

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
        in_valid = v;
        in_instr = ins;
        in_pc    = XLEN'(pc);
    endtask

    initial begin
        vecs[0]  = '{"addi",    32'hFFB00093, 12'b1001_0000_0000, 32'hFFFFFFFB, 5'd1,  5'd0,  5'd27, 3'b001};
        vecs[1]  = '{"sw",      32'h00112423, 12'b0011_0000_0000, 32'h00000008, 5'd8,  5'd2,  5'd1,  3'b010};
        vecs[2]  = '{"add",     32'h006281B3, 12'b1000_0000_0000, 32'h00000000, 5'd3,  5'd5,  5'd6,  3'b011};
        vecs[3]  = '{"beq",     32'hFE000EE3, 12'b0000_1000_0000, 32'hFFFFFFFC, 5'd29, 5'd0,  5'd0,  3'b110};
        vecs[4]  = '{"jal",     32'h008000EF, 12'b1000_0100_0000, 32'h00000008, 5'd1,  5'd0,  5'd8,  3'b110};
        vecs[5]  = '{"jalr_x0", 32'h00008067, 12'b0001_0010_0000, 32'h00000000, 5'd0,  5'd1,  5'd0,  3'b110};
        vecs[6]  = '{"lui",     32'h123452B7, 12'b1001_0001_0000, 32'h12345000, 5'd5,  5'd8,  5'd3,  3'b011};
        vecs[7]  = '{"auipc",   32'hFFFFF397, 12'b1001_0000_1000, 32'hFFFFF000, 5'd7,  5'd31, 5'd31, 3'b001};
        vecs[8]  = '{"lw",      32'hFFC12283, 12'b1101_0000_0000, 32'hFFFFFFFC, 5'd5,  5'd2,  5'd28, 3'b000};
        vecs[9]  = '{"illegal", 32'h0000000B, 12'b0000_0000_0010, 32'h00000000, 5'd0,  5'd0,  5'd0,  3'b000};
        vecs[10] = '{"nop_x0",  32'h00000013, 12'b0001_0000_0000, 32'h00000000, 5'd0,  5'd0,  5'd0,  3'b001};
`ifdef DECODE_MULDIV_EN
        vecs[11] = '{"mul",     32'h023100B3, 12'b1000_0000_0001, 32'h00000000, 5'd1,  5'd2,  5'd3,  3'b011};
`else
        vecs[11] = '{"mul",     32'h023100B3, 12'b0000_0000_0010, 32'h00000000, 5'd1,  5'd2,  5'd3,  3'b011};
`endif

        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1; ex_mem_read = 1'b0; ex_rd = 5'd0;
        drive(1'b1, 32'h00000013, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_halted",    64'(halted),    64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd0);
        chk("rst_ctrl",      64'(ctrl()),    64'd0);
        chk("rst_imm",       64'(out_imm),   64'd0);
        chk("rst_pc",        64'(out_pc),    64'd0);

        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 32'h0, 32'h0);
        #1 chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // back-to-back stream, one result per cycle
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(1'b1, vecs[i].instr, 32'h1000 + 32'(i) * 4);
            #1 chk({vecs[i].name, "_in_ready"}, 64'(in_ready), 64'd1);
            @(posedge clk);
            #1;
            chk({vecs[i].name, "_valid"}, 64'(out_valid), 64'd1);
            chk({vecs[i].name, "_ctrl"},  64'(ctrl()),    64'(vecs[i].ctrl));
            chk({vecs[i].name, "_imm"},   64'(out_imm),   64'(sx(vecs[i].imm)));
            chk({vecs[i].name, "_regs"},  64'({out_rd, out_rs1, out_rs2}),
                64'({vecs[i].rd, vecs[i].rs1, vecs[i].rs2}));
            chk({vecs[i].name, "_itype"}, 64'(out_itype), 64'(vecs[i].itype));
            chk({vecs[i].name, "_pc"},    64'(out_pc),    64'(XLEN'(32'h1000 + 32'(i) * 4)));
        end

        // load-use hazard on rs1 then rs2, then cleared by ex_rd=0
        @(negedge clk);
        drive(1'b1, 32'h006281B3, 32'h3000);
        ex_mem_read = 1'b1; ex_rd = 5'd5;
        #1 chk("haz_rs1_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1 chk("haz_bubble", 64'(out_valid), 64'd0);
        @(negedge clk);
        ex_rd = 5'd6;
        #1 chk("haz_rs2_in_ready", 64'(in_ready), 64'd0);
        ex_rd = 5'd0;
        #1 chk("haz_rd0_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        chk("haz_accept_valid", 64'(out_valid), 64'd1);
        chk("haz_accept_pc",    64'(out_pc),    64'(XLEN'(32'h3000)));
        @(negedge clk);
        drive(1'b1, 32'h123452B7, 32'h3004);
        ex_rd = 5'd8;
        #1 chk("haz_lui_no_rs1", 64'(in_ready), 64'd1);
        ex_mem_read = 1'b0; ex_rd = 5'd0;

        // backpressure with a branch held
        @(negedge clk);
        drive(1'b1, 32'hFE000EE3, 32'h4000);
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        drive(1'b1, 32'h006281B3, 32'h4004);
        for (int c = 0; c < 3; c++) begin
            #1 chk("bp_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk);
            #1;
            chk("bp_valid",  64'(out_valid),  64'd1);
            chk("bp_branch", 64'(out_branch), 64'd1);
            chk("bp_imm",    64'(out_imm),    64'(sx(32'hFFFFFFFC)));
            chk("bp_pc",     64'(out_pc),     64'(XLEN'(32'h4000)));
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1 chk("bp_release_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 chk("bp_next_rd", 64'(out_rd), 64'd3);

        // flush with a bundle held and input offered
        @(negedge clk);
        out_ready = 1'b0; flush = 1'b1;
        drive(1'b1, 32'h008000EF, 32'h5000);
        #1 chk("flush_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1 chk("flush_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        flush = 1'b0;
        @(posedge clk);
        #1;
        chk("flush_retry_jal", 64'(out_jal), 64'd1);
        chk("flush_retry_pc",  64'(out_pc),  64'(XLEN'(32'h5000)));

        // halt: sticky through flush, cleared only by reset
        @(negedge clk);
        out_ready = 1'b1;
        drive(1'b1, 32'h0000007F, 32'h6000);
        @(posedge clk);
        #1;
        chk("halt_hlt",    64'(out_hlt),  64'd1);
        chk("halt_ctrl",   64'(ctrl()),   64'b0000_0000_0100);
        chk("halt_halted", 64'(halted),   64'd1);
        @(negedge clk);
        out_ready = 1'b0;
        drive(1'b1, 32'h006281B3, 32'h6004);
        repeat (2) begin
            #1 chk("halt_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk);
            #1 chk("halt_held", 64'(out_valid), 64'd1);
            @(negedge clk);
        end
        flush = 1'b1;
        #1 chk("halt_flush_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1 chk("halt_flush_halted", 64'(halted), 64'd1);
        @(negedge clk);
        flush = 1'b0; out_ready = 1'b1;
        #1 chk("halt_after_flush_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("halt_sticky", 64'(halted), 64'd1);

        // reset while a bundle is held under backpressure
        out_ready = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 32'h00112423, 32'h7000);
        @(posedge clk);
        #1;
        chk("rst2_valid",  64'(out_valid), 64'd1);
        chk("rst2_halted", 64'(halted),    64'd0);
        chk("rst2_ctrl",   64'(ctrl()),    64'b0011_0000_0000);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_midstall_valid", 64'(out_valid), 64'd0);
        chk("rst_midstall_imm",   64'(out_imm),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, handshaked instruction-decode pipeline stage: the successor to the combinational instruction decoder. Takes one 32-bit RV32I-style instruction plus its PC from fetch, decodes control signals, generates the sign-extended immediate at a configurable datapath width, detects load-use hazards against the execute stage, latches halt, and presents one decoded bundle per cycle to execute over a valid/ready interface.

## Interface
- XLEN, 32 — datapath width for `out_pc` and `out_imm`; legal values 32 or 64.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  fetch presents `in_instr` and `in_pc`.
- in_ready  out  1  stage accepts the input this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  PC of `in_instr`.
- ex_mem_read  in  1  instruction in execute is a load.
- ex_rd  in  5  destination of the instruction in execute.
- flush  in  1  discard the held bundle and refuse input this cycle.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute accepts the bundle.
- out_pc  out  XLEN  registered copy of `in_pc`.
- out_rs1, out_rs2, out_rd  out  5 each  `instr[19:15]`, `[24:20]`, `[11:7]`.
- out_funct3  out  3 / out_funct7  out  7  `instr[14:12]`, `[31:25]`.
- out_itype  out  3  `opcode[6:4]`.
- out_imm  out  XLEN  sign-extended immediate.
- out_reg_write, out_mem_read, out_mem_write, out_alu_src, out_branch, out_jal, out_jalr, out_lui, out_auipc, out_hlt, out_illegal  out  1 each  decoded controls.
- out_mul  out  1  M-extension op (forced 0 when not configured).
- halted  out  1  stage has forwarded a halt and stopped accepting input.

## Operation
- Opcode decode (exact 7-bit match): 0110011 R; 0010011 I-ALU; 0000011 load; 0100011 store; 1100011 branch; 1101111 JAL; 1100111 JALR; 0110111 LUI; 0010111 AUIPC; 1111111 halt. Any other opcode sets `out_illegal`=1 and clears all other controls.
- Controls: `reg_write` for R, I-ALU, load, JAL, JALR, LUI, AUIPC; `mem_read` for load; `mem_write` for store; `alu_src` for I-ALU, load, store, JALR, LUI, AUIPC; `branch` for branch; `hlt` for halt. `reg_write` is forced to 0 when rd=0.
- Immediates: I = `instr[31:20]`; S = `{[31:25],[11:7]}`; B = `{[31],[7],[30:25],[11:8],0}`; J = `{[31],[19:12],[20],[30:21],0}`; U = `{[31:12],12'b0}`. All are sign-extended from bit 31 to XLEN. R, halt and illegal give imm=0.
- Register use: rs1 is used by all except JAL, LUI, AUIPC, halt and illegal. rs2 is used by R, store and branch.
- Hazard (combinational) = `in_valid & ex_mem_read & ex_rd!=0 & ((rs1 used & rs1==ex_rd) | (rs2 used & rs2==ex_rd))`.
- `in_ready = !halted & !flush & !hazard & (!out_valid | out_ready)`.
- States:
  - RUN: normal operation.
  - HALTED: entered on the edge where a halt instruction is accepted. That bundle is still emitted with `out_hlt`=1. `halted` stays 1 and `in_ready` stays 0 until reset; `flush` does not leave HALTED.

## Timing
- Latency: an accepted input appears on `out_*` with `out_valid`=1 one cycle later.
- Throughput: 1 instruction/cycle when `out_ready`=1 and there is no hazard.
- Backpressure: while `out_valid & !out_ready`, every `out_*` holds stable.
- Hazard cycle: input not accepted. If the held bundle is consumed that cycle, `out_valid` goes 0 next cycle (bubble). The same instruction is accepted once the hazard clears.
- Flush: next edge `out_valid`<=0; input refused in the flush cycle; flush takes priority over acceptance.
- Reset: all `out_*` = 0, `out_valid` = 0, `halted` = 0, state RUN. `in_ready` rises the first cycle after deassertion. Reset mid-stall discards the held bundle.

## Configuration
- `DECODE_MULDIV_EN` defined: an R opcode with funct7=0000001 sets `out_mul`=1, and all R controls are kept.
- Not defined: `out_mul` is tied to 0, and R with funct7=0000001 decodes as illegal (`out_illegal`=1, no `reg_write`).

## Test plan
- Stream `addi x1,x0,-5` (0xFFB00093) then `sw x1,8(x2)` with `out_ready`=1 → one result per cycle; imm=0xFFFFFFFB (XLEN=64: 0xFFFFFFFFFFFFFFFB), then imm=8 with `mem_write`=1.
- `ex_mem_read`=1, `ex_rd`=5, input `add x3,x5,x6` → `in_ready`=0 and one bubble. Repeat with `ex_rd`=0 → no stall.
- Hold `out_ready`=0 for 3 cycles with a branch bundle held → outputs are stable and `in_ready`=0. B-imm for 0xFE000EE3 is -4.
- Input 0x0000007F → next cycle `out_hlt`=1; `halted`=1 from then on; `in_ready` stays 0 through a flush; cleared only by `rst_n`.
- `flush`=1 with a bundle held and `in_valid`=1 → `out_valid`=0 next cycle and the input is not consumed. Opcode 0x0000000B → `out_illegal`=1 with all controls 0.
- `mul x1,x2,x3` (0x023100B3) → `out_mul`=1 with the macro defined; `out_illegal`=1 without it.
